vram_rect_fill: RTL and testbench

Rectangle-fill write engine upstream of the 200×150×12-bit VRAM (15-bit address, row-major, address = y·200 + x). It accepts one fill command at a time over a valid/ready handshake and issues one VRAM write per `pclk` cycle until every pixel in the rectangle is written. It drives the VRAM write port (`wea`/`addra`/`dina`), while the display path reads through its own port. Used for frame clear, background paint and simple graphics.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/fill_addr_gen.sv | 58 +++++
 rtl/vram_rect_fill.sv | 117 +++++++++++
 tb/tb_vram_rect_fill.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA/VRAM constants and the fill-engine state type; also used by the
// scan-timing and display-data stages.
package vga_pkg;

    localparam int H_RES = 200;
    localparam int V_RES = 150;
    localparam int AW    = 15;
    localparam int DW    = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } fill_state_t;

    function automatic logic [7:0] clamp_coord(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/fill_addr_gen.sv
// Raster scan address generator: walks xl..xr within each row, yt..yb row by row,
// keeping a running row base so only the initial row needs a multiply.
module fill_addr_gen
    import vga_pkg::*;
(
    input  logic          pclk,
    input  logic          rstn,
    input  logic          load,
    input  logic          step,
    input  logic [7:0]    xl,
    input  logic [7:0]    xr,
    input  logic [7:0]    yt,
    input  logic [7:0]    yb,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam logic [AW-1:0] ROW_STEP = AW'(H_RES);

    logic [7:0]    x;
    logic [7:0]    y;
    logic [AW-1:0] row_base;
    logic [AW-1:0] top_base;
    logic [AW-1:0] next_base;

    assign top_base  = AW'(yt) * ROW_STEP;
    assign next_base = row_base + ROW_STEP;

    // addr and last always describe the pixel currently being written
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
            addr     <= '0;
            last     <= 1'b0;
        end else if (load) begin
            x        <= xl;
            y        <= yt;
            row_base <= top_base;
            addr     <= top_base + AW'(xl);
            last     <= (xl == xr) && (yt == yb);
        end else if (step) begin
            if (x < xr) begin
                x    <= x + 8'd1;
                addr <= addr + AW'(1);
                last <= ((x + 8'd1) == xr) && (y == yb);
            end else begin
                x        <= xl;
                y        <= y + 8'd1;
                row_base <= next_base;
                addr     <= next_base + AW'(xl);
                last     <= (xl == xr) && ((y + 8'd1) == yb);
            end
        end
    end

endmodule

// File: rtl/vram_rect_fill.sv
// Rectangle-fill write engine: accepts one fill command and writes every pixel
// of the clamped, sorted rectangle into VRAM at one pixel per pclk.
//
// state | meaning
// IDLE  | ready for a command
// SETUP | clamp/sort captured corners, load scan counters
// FILL  | one VRAM write per cycle
// DONE  | one-cycle completion pulse
module vram_rect_fill
    import vga_pkg::*;
(
    input  logic          pclk,
    input  logic          rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [7:0]    cmd_x0,
    input  logic [7:0]    cmd_y0,
    input  logic [7:0]    cmd_x1,
    input  logic [7:0]    cmd_y1,
    input  logic [DW-1:0] cmd_color,
    output logic          busy,
    output logic          done,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata
);

    localparam logic [7:0] X_MAX = 8'(H_RES - 1);
    localparam logic [7:0] Y_MAX = 8'(V_RES - 1);

    fill_state_t   state, state_nxt;
    logic [7:0]    x0_q, y0_q, x1_q, y1_q;
    logic [DW-1:0] color_q;
    logic [7:0]    xa, xb, ya, yb_c;
    logic [7:0]    xl, xr, yt, yb;
    logic          load, step, last, accept;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == SETUP) || (state == FILL);
    assign accept    = cmd_valid && cmd_ready;

    // Bounds stay valid through FILL because the captured corners only change on accept
    assign xa   = clamp_coord(x0_q, X_MAX);
    assign xb   = clamp_coord(x1_q, X_MAX);
    assign ya   = clamp_coord(y0_q, Y_MAX);
    assign yb_c = clamp_coord(y1_q, Y_MAX);
    assign xl   = (xa < xb) ? xa : xb;
    assign xr   = (xa < xb) ? xb : xa;
    assign yt   = (ya < yb_c) ? ya : yb_c;
    assign yb   = (ya < yb_c) ? yb_c : ya;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE:  if (cmd_valid) state_nxt = SETUP;
            SETUP: begin
                load      = 1'b1;
                state_nxt = FILL;
            end
            FILL: begin
                if (last) state_nxt = DONE;
                else      step      = 1'b1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
        end else if (accept) begin
            x0_q    <= cmd_x0;
            y0_q    <= cmd_y0;
            x1_q    <= cmd_x1;
            y1_q    <= cmd_y1;
            color_q <= cmd_color;
        end
    end

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            we    <= 1'b0;
            done  <= 1'b0;
            wdata <= '0;
        end else begin
            we   <= (state_nxt == FILL);
            done <= (state == FILL) && last;
            if (load) wdata <= color_q;
        end
    end

    fill_addr_gen u_addr_gen (
        .pclk (pclk),
        .rstn (rstn),
        .load (load),
        .step (step),
        .xl   (xl),
        .xr   (xr),
        .yt   (yt),
        .yb   (yb),
        .addr (waddr),
        .last (last)
    );

endmodule

// File: tb/tb_vram_rect_fill.sv
// Directed and randomized checks of vram_rect_fill against a pixel-list model
// built from the rectangle rules (clamp, sort, raster order).
module tb_vram_rect_fill;
    import vga_pkg::*;

    logic          pclk = 1'b0;
    logic          rstn;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [7:0]    cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
    logic [DW-1:0] cmd_color = '0;
    logic          busy, done, we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    vram_rect_fill dut (
        .pclk      (pclk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_x1    (cmd_x1),
        .cmd_y1    (cmd_y1),
        .cmd_color (cmd_color),
        .busy      (busy),
        .done      (done),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Expected write addresses: clamp, sort, then every pixel row by row
    task automatic build_exp(input int x0, input int y0, input int x1, input int y1);
        int cx0, cx1, cy0, cy1, xl, xr, yt, yb;
        cx0 = (x0 > H_RES - 1) ? H_RES - 1 : x0;
        cx1 = (x1 > H_RES - 1) ? H_RES - 1 : x1;
        cy0 = (y0 > V_RES - 1) ? V_RES - 1 : y0;
        cy1 = (y1 > V_RES - 1) ? V_RES - 1 : y1;
        xl = (cx0 < cx1) ? cx0 : cx1;
        xr = (cx0 < cx1) ? cx1 : cx0;
        yt = (cy0 < cy1) ? cy0 : cy1;
        yb = (cy0 < cy1) ? cy1 : cy0;
        exp_q.delete();
        for (int yy = yt; yy <= yb; yy++)
            for (int xx = xl; xx <= xr; xx++)
                exp_q.push_back(yy * H_RES + xx);
    endtask

    task automatic present(input int x0, input int y0, input int x1, input int y1, input int col);
        cmd_x0    = 8'(x0);
        cmd_y0    = 8'(y0);
        cmd_x1    = 8'(x1);
        cmd_y1    = 8'(y1);
        cmd_color = DW'(col);
        cmd_valid = 1'b1;
    endtask

    // Returns 1 ns after the accepting edge T0
    task automatic accept(input string tag);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge pclk); #1;
            n++;
        end
        chk({tag, "_ready"}, cmd_ready, 1);
        @(posedge pclk); #1;
    endtask

    task automatic track(input string tag, input int col, input bit hold);
        if (!hold) begin
            cmd_valid = 1'b0;
            cmd_x0 = 8'($urandom);
            cmd_y0 = 8'($urandom);
            cmd_x1 = 8'($urandom);
            cmd_y1 = 8'($urandom);
            cmd_color = DW'($urandom);
        end
        chk({tag, "_setup_busy"}, busy, 1);
        chk({tag, "_setup_we"}, we, 0);
        chk({tag, "_setup_ready"}, cmd_ready, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge pclk); #1;
            chk({tag, "_we"}, we, 1);
            chk({tag, "_addr"}, waddr, exp_q[k]);
            chk({tag, "_data"}, wdata, col);
            chk({tag, "_done_early"}, done, 0);
            chk({tag, "_ready_busy"}, cmd_ready, 0);
        end
        @(posedge pclk); #1;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_done_we"}, we, 0);
        chk({tag, "_done_busy"}, busy, 0);
        chk({tag, "_done_ready"}, cmd_ready, 0);
        chk({tag, "_addr_hold"}, waddr, exp_q[exp_q.size() - 1]);
        @(posedge pclk); #1;
        chk({tag, "_idle_done"}, done, 0);
        chk({tag, "_idle_ready"}, cmd_ready, 1);
        chk({tag, "_idle_we"}, we, 0);
    endtask

    task automatic run(input string tag, input int x0, input int y0, input int x1, input int y1, input int col);
        build_exp(x0, y0, x1, y1);
        present(x0, y0, x1, y1, col);
        accept(tag);
        track(tag, col, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, cmd_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_we"}, we, 0);
        chk({tag, "_addr"}, waddr, 0);
        chk({tag, "_data"}, wdata, 0);
    endtask

    function automatic int clip255(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b1;
        #2 rstn = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        chk_reset_vals("reset");
        @(negedge pclk) rstn = 1'b1;
        @(posedge pclk); #1;

        run("single", 5, 7, 5, 7, 'hF00);
        run("swapped", 10, 3, 8, 2, 'h0F0);
        run("clamp", 198, 148, 250, 200, 'h00F);

        // Second command held on cmd_valid throughout the first
        build_exp(2, 2, 4, 3);
        present(2, 2, 4, 3, 'h123);
        accept("b2b_a");
        present(7, 1, 5, 1, 'h456);
        track("b2b_a", 'h123, 1'b1);
        build_exp(7, 1, 5, 1);
        accept("b2b_b");
        track("b2b_b", 'h456, 1'b0);

        for (int i = 0; i < 24; i++) begin
            int x0, y0, x1, y1, col;
            x0 = $urandom_range(0, 255);
            y0 = $urandom_range(0, 255);
            x1 = clip255(x0 + $urandom_range(0, 14) - 7);
            y1 = clip255(y0 + $urandom_range(0, 14) - 7);
            col = $urandom_range(0, 4095);
            run("rand", x0, y0, x1, y1, col);
        end

        run("clear", 0, 0, 199, 149, 'h000);

        // Reset during the 50th write of a full clear
        build_exp(0, 0, 199, 149);
        present(0, 0, 199, 149, 'hABC);
        accept("rst_fill");
        cmd_valid = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge pclk); #1;
        end
        chk("rst_fill_we", we, 1);
        chk("rst_fill_addr", waddr, 49);
        #2 rstn = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        @(negedge pclk) rstn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge pclk); #1;
            chk("rst_after_we", we, 0);
            chk("rst_after_ready", cmd_ready, 1);
        end
        run("post_rst", 3, 0, 4, 1, 'h777);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
